// File: rtl/noc_switch_allocator_pkg.sv
// Shared constants and helpers for the 5x5 wormhole router switch allocator.
// Holds the port count and field widths, the flit-type encodings, the port
// index names, the per-output arbiter state type and the rotating-priority pick.
package noc_switch_allocator_pkg;

  localparam int unsigned NPORT  = 5;
  localparam int unsigned PORTW  = 3;
  localparam int unsigned FTYPEW = 3;

  // Flit-type encodings carried in flit bits 34:32
  localparam logic [FTYPEW-1:0] TYPE_HEAD     = 3'd1;
  localparam logic [FTYPEW-1:0] TYPE_DATA     = 3'd2;
  localparam logic [FTYPEW-1:0] TYPE_TAIL     = 3'd3;
  localparam logic [FTYPEW-1:0] TYPE_HEADTAIL = 3'd4;

  // Port indices
  localparam logic [PORTW-1:0] NORTH = 3'd0;
  localparam logic [PORTW-1:0] EAST  = 3'd1;
  localparam logic [PORTW-1:0] SOUTH = 3'd2;
  localparam logic [PORTW-1:0] WEST  = 3'd3;
  localparam logic [PORTW-1:0] LOCAL = 3'd4;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [PORTW-1:0] idx;
  } pick_t;

  // (p + 1) mod NPORT for a port index already known to be < NPORT
  function automatic logic [PORTW-1:0] wrap_inc(input logic [PORTW-1:0] p);
    return (p == PORTW'(NPORT - 1)) ? '0 : p + 1'b1;
  endfunction

  // First set bit of mask scanning ptr, ptr+1, ... mod NPORT
  function automatic pick_t rr_pick(input logic [NPORT-1:0] mask,
                                    input logic [PORTW-1:0] ptr);
    pick_t            r;
    logic [PORTW-1:0] idx;
    r   = '0;
    idx = ptr;
    for (int unsigned k = 0; k < NPORT; k++) begin
      if (!r.found && mask[idx]) begin
        r.found = 1'b1;
        r.idx   = idx;
      end
      idx = wrap_inc(idx);
    end
    return r;
  endfunction

endpackage

// File: rtl/noc_switch_allocator_out_arbiter.sv
// noc_out_arbiter: allocation logic for one output port.
// Runs round-robin among the inputs routed to this output while IDLE, and
// holds the output for the owning input from HEAD until its TAIL transfers.
//   clk, rst_   : clock, synchronous active-high reset
//   req         : bit p = input p is valid and routed to this output
//   req_ftype   : {p4..p0} flit types, FTYPEW bits each
//   out_rdy     : downstream of this output can accept a flit
//   grant       : bit p = input p transfers through this output this cycle
//   sel         : input index driven onto this output
//   vld         : this output carries a valid flit this cycle
//   lck         : this output is locked to a packet
//   err         : combinational protocol-violation term for this output
module noc_out_arbiter
  import noc_switch_allocator_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_,
  input  logic [NPORT-1:0]        req,
  input  logic [NPORT*FTYPEW-1:0] req_ftype,
  input  logic                    out_rdy,
  output logic [NPORT-1:0]        grant,
  output logic [PORTW-1:0]        sel,
  output logic                    vld,
  output logic                    lck,
  output logic                    err
);

  arb_state_t       state, state_nxt;
  logic [PORTW-1:0] owner, owner_nxt;
  logic [PORTW-1:0] rr_ptr, rr_ptr_nxt;

  logic [FTYPEW-1:0] ftype [NPORT];
  logic [NPORT-1:0]  head_req;
  logic [NPORT-1:0]  body_req;
  pick_t             pick;

  always_comb begin
    for (int unsigned p = 0; p < NPORT; p++) begin
      ftype[p]    = req_ftype[p*FTYPEW +: FTYPEW];
      head_req[p] = req[p] && (ftype[p] == TYPE_HEAD || ftype[p] == TYPE_HEADTAIL);
      body_req[p] = req[p] && (ftype[p] == TYPE_DATA || ftype[p] == TYPE_TAIL);
    end
  end

  always_comb begin
    pick       = rr_pick(head_req, rr_ptr);
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    grant      = '0;
    sel        = (state == ARB_LOCKED) ? owner : '0;
    vld        = 1'b0;
    err        = 1'b0;
    lck        = (state == ARB_LOCKED);
    unique case (state)
      ARB_IDLE: begin
        // Body flits with no packet open here are violations and never granted
        err = |body_req;
        if (pick.found && out_rdy) begin
          vld              = 1'b1;
          sel              = pick.idx;
          grant[pick.idx]  = 1'b1;
          if (ftype[pick.idx] == TYPE_HEAD) begin
            state_nxt = ARB_LOCKED;
            owner_nxt = pick.idx;
          end else begin
            rr_ptr_nxt = wrap_inc(pick.idx);
          end
        end
      end
      ARB_LOCKED: begin
        // A head from the owner mid-packet is a violation and is never granted
        err = head_req[owner];
        if (req[owner] && !head_req[owner] && out_rdy) begin
          vld          = 1'b1;
          grant[owner] = 1'b1;
          if (ftype[owner] == TYPE_TAIL) begin
            state_nxt  = ARB_IDLE;
            rr_ptr_nxt = wrap_inc(owner);
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state  <= ARB_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

endmodule

// File: rtl/noc_switch_allocator.sv
// noc_switch_allocator: switch allocator for the 5x5 wormhole router.
// Decodes each input's requested output, runs one noc_out_arbiter per output,
// merges the per-output grants and registers a one-cycle error pulse.
//   clk, rst_  : clock, synchronous active-high reset
//   req_valid  : bit p = input p presents a flit
//   req_port   : {p4..p0} requested output index, PORTW bits each
//   req_ftype  : {p4..p0} flit type, FTYPEW bits each
//   out_rdy    : bit o = downstream of output o can accept a flit
//   grant      : bit p = input p's flit transfers this cycle
//   xbar_sel   : {o4..o0} input index driven onto output o
//   xbar_vld   : bit o = output o carries a valid flit
//   out_lck    : bit o = output o is locked to a packet
//   err        : registered one-cycle protocol-violation pulse
module noc_switch_allocator
  import noc_switch_allocator_pkg::*;
(
  input  logic         clk,
  input  logic         rst_,
  input  logic [4:0]   req_valid,
  input  logic [14:0]  req_port,
  input  logic [14:0]  req_ftype,
  input  logic [4:0]   out_rdy,
  output logic [4:0]   grant,
  output logic [14:0]  xbar_sel,
  output logic [4:0]   xbar_vld,
  output logic [4:0]   out_lck,
  output logic         err
);

  logic [NPORT-1:0] route   [NPORT];  // route[o][p]: input p valid and routed to o
  logic [NPORT-1:0] grant_o [NPORT];
  logic [NPORT-1:0] arb_err;
  logic             bad_port;
  logic [PORTW-1:0] port_p;

  always_comb begin
    bad_port = 1'b0;
    port_p   = '0;
    for (int unsigned o = 0; o < NPORT; o++) begin
      route[o] = '0;
    end
    for (int unsigned p = 0; p < NPORT; p++) begin
      port_p = req_port[p*PORTW +: PORTW];
      if (req_valid[p] && port_p > PORTW'(NPORT - 1)) begin
        bad_port = 1'b1;
      end
      for (int unsigned o = 0; o < NPORT; o++) begin
        route[o][p] = req_valid[p] && (port_p == PORTW'(o));
      end
    end
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_out
    noc_out_arbiter u_arb (
      .clk       (clk),
      .rst_      (rst_),
      .req       (route[o]),
      .req_ftype (req_ftype),
      .out_rdy   (out_rdy[o]),
      .grant     (grant_o[o]),
      .sel       (xbar_sel[o*PORTW +: PORTW]),
      .vld       (xbar_vld[o]),
      .lck       (out_lck[o]),
      .err       (arb_err[o])
    );
  end

  // Each input routes to one output, so the OR never merges two bits per input
  always_comb begin
    grant = '0;
    for (int unsigned o = 0; o < NPORT; o++) begin
      grant = grant | grant_o[o];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      err <= 1'b0;
    end else begin
      err <= bad_port | (|arb_err);
    end
  end

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Self-checking bench for noc_switch_allocator: directed steps followed by
// random traffic, every cycle compared against a packet-level reference model.
module tb_noc_switch_allocator;
  import noc_switch_allocator_pkg::*;

  logic        clk = 1'b0;
  logic        rst_;
  logic [4:0]  req_valid;
  logic [14:0] req_port;
  logic [14:0] req_ftype;
  logic [4:0]  out_rdy;
  logic [4:0]  grant;
  logic [14:0] xbar_sel;
  logic [4:0]  xbar_vld;
  logic [4:0]  out_lck;
  logic        err;

  always #5 clk = ~clk;

  noc_switch_allocator dut (
    .clk       (clk),
    .rst_      (rst_),
    .req_valid (req_valid),
    .req_port  (req_port),
    .req_ftype (req_ftype),
    .out_rdy   (out_rdy),
    .grant     (grant),
    .xbar_sel  (xbar_sel),
    .xbar_vld  (xbar_vld),
    .out_lck   (out_lck),
    .err       (err)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Flit-type values used by the bench
  localparam int TH  = 1;
  localparam int TD  = 2;
  localparam int TT  = 3;
  localparam int THT = 4;

  // Stimulus as seen by the model
  int v_valid [5];
  int v_port  [5];
  int v_type  [5];

  // Reference model: which outputs hold an open packet, who owns it, who is next
  bit m_lock [5];
  int m_own  [5];
  int m_ptr  [5];
  bit m_err;

  function automatic bit is_head(int ty);
    return ty == TH || ty == THT;
  endfunction

  task automatic clear_in();
    for (int p = 0; p < 5; p++) begin
      v_valid[p] = 0;
      v_port[p]  = 0;
      v_type[p]  = 0;
    end
    req_valid = '0;
    req_port  = '0;
    req_ftype = '0;
  endtask

  task automatic drive(int p, int port, int ty);
    v_valid[p] = 1;
    v_port[p]  = port;
    v_type[p]  = ty;
    req_valid[p]           = 1'b1;
    req_port[p*3 +: 3]     = 3'(port);
    req_ftype[p*3 +: 3]    = 3'(ty);
  endtask

  task automatic check(string tag, logic [14:0] obs, logic [14:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply current inputs for one cycle (called just after a negedge)
  task automatic step(bit do_rst);
    logic [4:0]  eg, ev, el;
    logic [14:0] es;
    bit          en;
    int          win [5];
    int          p;
    rst_ = do_rst;
    #1;
    eg = '0; ev = '0; es = '0; el = '0; en = 0;
    for (int q = 0; q < 5; q++) begin
      if (v_valid[q] != 0 && v_port[q] > 4) en = 1;
    end
    for (int o = 0; o < 5; o++) begin
      win[o] = -1;
      el[o]  = m_lock[o];
      if (!m_lock[o]) begin
        for (int k = 0; k < 5; k++) begin
          p = (m_ptr[o] + k) % 5;
          if (win[o] < 0 && v_valid[p] != 0 && v_port[p] == o && is_head(v_type[p]))
            win[o] = p;
        end
        for (int q = 0; q < 5; q++) begin
          if (v_valid[q] != 0 && v_port[q] == o && (v_type[q] == TD || v_type[q] == TT))
            en = 1;
        end
      end else begin
        p = m_own[o];
        if (v_valid[p] != 0 && v_port[p] == o) begin
          if (is_head(v_type[p])) en = 1;
          else win[o] = p;
        end
      end
      es[o*3 +: 3] = m_lock[o] ? 3'(m_own[o]) : 3'd0;
      if (win[o] >= 0 && out_rdy[o]) begin
        ev[o]        = 1'b1;
        eg[win[o]]   = 1'b1;
        es[o*3 +: 3] = 3'(win[o]);
      end else begin
        win[o] = -1;
      end
    end
    check("grant",    15'(grant),    15'(eg));
    check("xbar_sel", xbar_sel,      es);
    check("xbar_vld", 15'(xbar_vld), 15'(ev));
    check("out_lck",  15'(out_lck),  15'(el));
    check("err",      15'(err),      15'(m_err));
    @(posedge clk);
    if (do_rst) begin
      for (int o = 0; o < 5; o++) begin
        m_lock[o] = 0; m_own[o] = 0; m_ptr[o] = 0;
      end
      m_err = 0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (win[o] >= 0) begin
          if (!m_lock[o]) begin
            if (v_type[win[o]] == TH) begin
              m_lock[o] = 1; m_own[o] = win[o];
            end else begin
              m_ptr[o] = (win[o] + 1) % 5;
            end
          end else if (v_type[win[o]] == TT) begin
            m_lock[o] = 0; m_ptr[o] = (m_own[o] + 1) % 5;
          end
        end
      end
      m_err = en;
    end
    @(negedge clk);
  endtask

  initial begin
    int owned;
    clear_in();
    out_rdy = '1;
    rst_    = 1'b1;
    for (int o = 0; o < 5; o++) begin
      m_lock[o] = 0; m_own[o] = 0; m_ptr[o] = 0;
    end
    m_err = 0;
    @(negedge clk);

    // Reset, then idle state
    step(1); step(1);
    step(0);

    // Single packet from input 0 to output 1
    drive(0, 1, TH); step(0);
    drive(0, 1, TD); step(0);
    drive(0, 1, TT); step(0);
    clear_in();      step(0);

    // Two heads contend for output 4; the loser wins the next packet
    drive(2, 4, TH); drive(3, 4, TH); step(0);
    drive(2, 4, TD); step(0);
    drive(2, 4, TT); step(0);
    clear_in(); drive(3, 4, TH); step(0);
    drive(3, 4, TT); drive(2, 4, TH); step(0);
    clear_in(); drive(2, 4, TH); drive(3, 4, TH); step(0);
    drive(2, 4, TT); drive(3, 4, TT); step(0);
    clear_in(); step(0);

    // Back-pressure mid-packet on output 1
    drive(0, 1, TH); step(0);
    out_rdy[1] = 1'b0;
    drive(0, 1, TD);
    for (int i = 0; i < 4; i++) step(0);
    out_rdy[1] = 1'b1;
    step(0);
    drive(0, 1, TT); step(0);
    clear_in(); step(0);

    // Protocol violations: body flit to idle output, out-of-range port
    drive(1, 3, TD); step(0);
    clear_in(); step(0); step(0);
    drive(1, 5, TH); step(0);
    clear_in(); step(0); step(0);

    // All inputs send single-flit packets to distinct outputs
    drive(0, 2, THT); drive(1, 3, THT); drive(2, 4, THT);
    drive(3, 0, THT); drive(4, 1, THT); step(0);
    clear_in(); step(0);

    // Reset mid-packet, then a stale body flit
    drive(0, 0, TH); drive(1, 2, TH); step(0);
    clear_in(); step(0);
    step(1);
    step(0);
    drive(0, 0, TD); step(0);
    clear_in(); step(0); step(0);

    // Random traffic, biased so owners mostly continue their packets
    for (int cyc = 0; cyc < 600; cyc++) begin
      clear_in();
      for (int o = 0; o < 5; o++) out_rdy[o] = ($urandom_range(0, 99) < 85);
      for (int p = 0; p < 5; p++) begin
        if ($urandom_range(0, 3) != 0) begin
          owned = -1;
          for (int o = 0; o < 5; o++) if (m_lock[o] && m_own[o] == p) owned = o;
          if (owned >= 0 && $urandom_range(0, 9) < 8) begin
            drive(p, owned, ($urandom_range(0, 2) == 0) ? TT : TD);
          end else begin
            drive(p,
                  ($urandom_range(0, 15) == 0) ? int'($urandom_range(5, 7))
                                               : int'($urandom_range(0, 4)),
                  int'($urandom_range(1, 4)));
          end
        end
      end
      step($urandom_range(0, 149) == 0);
    end

    clear_in();
    step(0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/noc_switch_allocator.md
Name: noc_switch_allocator

Overview:
- Switch allocator for the 5x5 wormhole router: ports 0 NORTH, 1 EAST, 2 SOUTH, 3 WEST, 4 LOCAL.
- For each output port it runs a round-robin arbiter among the 5 input ports.
- A winning HEAD flit locks the output to that input until the packet's TAIL flit has transferred.
- It drives the crossbar select and the per-input grants. The route computation unit sits before it; the crossbar and output registers sit after it.

Parameters:
- NPORT, 5, number of input/output ports (fixed 5; only this value is supported).
- PORTW, 3, width of a port index.
- FTYPEW, 3, width of the flit-type field (flit bits 34:32).

Ports:
- clk  input  1  system clock.
- rst_  input  1  synchronous reset, active-high.
- req_valid  input  5  bit p: input port p presents a flit this cycle.
- req_port  input  15  {p4..p0}, 3 bits each: output port index requested by input p (from route computation).
- req_ftype  input  15  {p4..p0}, 3 bits each: flit type of input p's flit, using the `TYPE_*` encodings.
- out_rdy  input  5  bit o: downstream of output o can accept a flit (derived from iack).
- grant  output  5  bit p: input p's flit transfers this cycle.
- xbar_sel  output  15  {o4..o0}, 3 bits each: input index driven onto output o.
- xbar_vld  output  5  bit o: output o carries a valid flit this cycle.
- out_lck  output  5  bit o: output o is locked to a packet.
- err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Timing model:
  - State is registered.
  - grant, xbar_sel and xbar_vld are combinational from state plus the current inputs (zero-cycle allocation).
  - A transfer on output o occurs when xbar_vld[o]=1, which implies out_rdy[o]=1.
- Per-output state:
  - state ∈ {IDLE, LOCKED}.
  - owner[2:0].
  - rr_ptr[2:0]: the highest-priority input.
- Reset (rst_=1 at a posedge), for all outputs: state=IDLE, owner=0, rr_ptr=0, err=0.
  - With req_valid=0 after reset: grant=0, xbar_vld=0, xbar_sel=0, out_lck=0.
  - A reset asserted mid-packet drops all locks the same edge; no partial-packet recovery.
- Eligibility in IDLE: input p is eligible for output o iff
  - req_valid[p], and
  - req_port[p]==o, and
  - ftype is HEAD or HEADTAIL.
- Selection in IDLE: the winner is the first eligible input scanning rr_ptr, rr_ptr+1, … mod 5.
- Eligibility in LOCKED: only input owner is eligible, and only if req_valid[owner] and req_port[owner]==o. All other inputs stall (grant=0).
- Output drive:
  - If a winner exists and out_rdy[o]=1: xbar_vld[o]=1, xbar_sel[o]=winner, grant[winner]=1.
  - Otherwise xbar_vld[o]=0, and xbar_sel[o] holds owner (LOCKED) or 0 (IDLE).
  - out_rdy[o]=0 changes no state, including rr_ptr.
- State transitions on a transfer:
  - IDLE + HEAD: go LOCKED, owner=winner.
  - IDLE + HEADTAIL: stay IDLE, rr_ptr=(winner+1) mod 5.
  - LOCKED + DATA: no state change.
  - LOCKED + TAIL: go IDLE, rr_ptr=(owner+1) mod 5.
- Tail and new head on the same output in the same cycle: the new head is not eligible that cycle (state is still LOCKED). It arbitrates in the next cycle.
- Independence: all 5 outputs arbitrate independently. An input requests one output per cycle, so grant has at most one bit per input by construction.
- err pulses for one cycle, registered, on any of:
  - req_valid[p] with req_port[p]>4;
  - DATA or TAIL presented to an IDLE output;
  - a HEAD or HEADTAIL presented by the owner of a LOCKED output.
- Offending flits are never granted. err does not alter any lock state.
- out_lck[o] = (state==LOCKED).

Decomposition:
- Shared constants in define.h:
  - `TYPE_HEAD, `TYPE_DATA, `TYPE_TAIL, `TYPE_HEADTAIL;
  - port indices NORTH..LOCAL = 0..4;
  - PORTW.
- One sub-module, noc_out_arbiter, instantiated 5 times (one per output). It contains the IDLE/LOCKED FSM, owner, rr_ptr, the rotating priority pick and the local err terms.
- The top level does req_port decode, the OR-reduction of grants and the err OR.

Test Plan:
1. After reset, input 0 sends HEAD/DATA/TAIL to output 1 with out_rdy=5'b11111 → grant[0]=1 for 3 consecutive cycles, xbar_sel[1]=0, out_lck[1]=1 after the HEAD edge, 0 after the TAIL edge, then rr_ptr[1]=1.
2. Inputs 2 and 3 present HEAD to output 4 in the same cycle with rr_ptr=0 → input 2 wins, input 3 stalls until cycle+1 after input 2's TAIL. Repeat with both again: input 3 wins (rr_ptr=3).
3. Mid-packet, out_rdy[1]=0 for 4 cycles → grant[0]=0 and xbar_vld[1]=0 those cycles, xbar_sel[1] stays 0, out_lck[1] stays 1. Transfer resumes when out_rdy returns.
4. Input 1 sends DATA to idle output 3 → no grant, err=1 for exactly one cycle, out_lck[3]=0. Also req_port=5 → err pulse, no grant.
5. All 5 inputs send HEADTAIL to 5 distinct outputs (0→2, 1→3, 2→4, 3→0, 4→1) in one cycle → grant=5'b11111, xbar_vld=5'b11111, out_lck stays 0.
6. rst_ asserted while outputs 0 and 2 are LOCKED → next cycle out_lck=0, all rr_ptr=0. A subsequent DATA flit from a former owner causes an err pulse.
